// File: rtl/ulpi_phy_ctrl_if.sv
// rtl/ulpi_phy_ctrl_if.sv - ULPI link/PHY bus bundle
interface ulpi_phy_ctrl_if;
  logic [7:0] data_in;
  logic       stp;
  logic       dir;
  logic       nxt;
  logic [7:0] data_out;

  modport master (output data_in, stp, input dir, nxt, data_out);
  modport slave  (input data_in, stp, output dir, nxt, data_out);
endinterface

// File: rtl/ulpi_phy_ctrl.sv
// rtl/ulpi_phy_ctrl.sv - ULPI PHY-side controller: TXCMD decode, TX/RX data paths, register access
module ulpi_phy_ctrl #(
  parameter int RX_DEPTH   = 4,
  parameter int TX_NXT_GAP = 0
) (
  input  logic           clock,
  input  logic           reset,
  ulpi_phy_ctrl_if.slave ulpi,
  output logic           tx_valid,
  output logic [7:0]     tx_data,
  output logic           tx_last,
  input  logic           rx_valid,
  input  logic [7:0]     rx_data,
  input  logic           rx_last,
  output logic           rx_ready,
  input  logic [1:0]     linestate,
  output logic [5:0]     reg_addr,
  output logic [7:0]     reg_wdata,
  output logic           reg_we,
  input  logic [7:0]     reg_rdata
);

  localparam int AW = $clog2(RX_DEPTH);

  typedef enum logic [3:0] {
    IDLE, TX, REG_WR, RD_TURN, RD_DATA, RX_TURN, RX_CMD, RX_DATA, TURN_BACK
  } state_t;

  state_t     state, state_next;
  logic       sub, sub_next;
  logic [7:0] tx_hold;
  logic [7:0] gap_cnt;
  logic       gap_hold;
  logic [1:0] ls_q, ls_rep;
  logic       pop, push;

  logic [8:0]  fifo_mem [RX_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full;
  logic [8:0]  head;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head       = fifo_mem[rd_ptr[AW-1:0]];
  // Push is blocked while full even if a pop happens the same cycle.
  assign rx_ready   = reset && !fifo_full;
  assign push       = rx_valid && rx_ready;
  assign gap_hold   = (TX_NXT_GAP > 0) && (gap_cnt == 8'(TX_NXT_GAP));

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= {rx_last, rx_data};
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      sub   <= 1'b0;
    end else begin
      state <= state_next;
      sub   <= sub_next;
    end
  end

  // sub qualifies a state: REG_WR data/stp phase, RD_TURN nxt/turnaround,
  // RX_TURN/RX_CMD packet (1) versus line-state-only report or end of packet (0).
  always_comb begin
    state_next = state;
    sub_next   = sub;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_next = RX_TURN;
          sub_next   = 1'b1;
        end else if (ulpi.data_in[7:6] == 2'b01) begin
          state_next = TX;
        end else if (ulpi.data_in[7:6] == 2'b10) begin
          state_next = REG_WR;
          sub_next   = 1'b0;
        end else if (ulpi.data_in[7:6] == 2'b11) begin
          state_next = RD_TURN;
          sub_next   = 1'b0;
        end else if (ls_q != ls_rep) begin
          state_next = RX_TURN;
          sub_next   = 1'b0;
        end
      end
      TX:        if (ulpi.stp) state_next = IDLE;
      REG_WR: begin
        if (!sub) sub_next = 1'b1;
        else if (ulpi.stp) state_next = IDLE;
      end
      RD_TURN: begin
        if (!sub) sub_next = 1'b1;
        else state_next = RD_DATA;
      end
      RD_DATA:   state_next = IDLE;
      RX_TURN:   state_next = RX_CMD;
      RX_CMD:    state_next = sub ? RX_DATA : TURN_BACK;
      RX_DATA: begin
        if (!fifo_empty && head[8]) begin
          state_next = RX_CMD;
          sub_next   = 1'b0;
        end
      end
      TURN_BACK: state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    ulpi.dir      = 1'b0;
    ulpi.nxt      = 1'b0;
    ulpi.data_out = 8'h00;
    tx_valid      = 1'b0;
    tx_data       = 8'h00;
    tx_last       = 1'b0;
    pop           = 1'b0;
    case (state)
      TX: begin
        ulpi.nxt = !gap_hold;
        tx_valid = ulpi.stp || !gap_hold;
        tx_data  = tx_valid ? tx_hold : 8'h00;
        tx_last  = ulpi.stp;
      end
      REG_WR:  ulpi.nxt = !sub;
      RD_TURN: begin
        ulpi.nxt = !sub;
        ulpi.dir = sub;
      end
      RD_DATA: begin
        ulpi.dir      = 1'b1;
        ulpi.data_out = reg_rdata;
      end
      RX_TURN: begin
        ulpi.dir = 1'b1;
        ulpi.nxt = sub;
      end
      RX_CMD: begin
        ulpi.dir      = 1'b1;
        ulpi.data_out = {2'b00, 1'b0, sub, 2'b00, ls_q};
      end
      RX_DATA: begin
        ulpi.dir = 1'b1;
        if (!fifo_empty) begin
          pop           = 1'b1;
          ulpi.nxt      = 1'b1;
          ulpi.data_out = head[7:0];
        end else begin
          ulpi.data_out = {4'b0001, 2'b00, ls_q};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      tx_hold   <= 8'h00;
      gap_cnt   <= 8'h00;
      reg_addr  <= 6'h00;
      reg_wdata <= 8'h00;
      reg_we    <= 1'b0;
      ls_q      <= 2'b00;
      ls_rep    <= 2'b00;
    end else begin
      ls_q   <= linestate;
      reg_we <= (state == REG_WR) && sub && ulpi.stp;
      case (state)
        IDLE: begin
          if (fifo_empty && ulpi.data_in[7:6] == 2'b01) begin
            tx_hold <= ulpi.data_in;
            gap_cnt <= 8'h00;
          end
          if (fifo_empty && ulpi.data_in[7]) reg_addr <= ulpi.data_in[5:0];
        end
        TX: begin
          if (!ulpi.stp) begin
            if (gap_hold) begin
              gap_cnt <= 8'h00;
            end else begin
              tx_hold <= ulpi.data_in;
              gap_cnt <= gap_cnt + 8'd1;
            end
          end
        end
        REG_WR: if (!sub) reg_wdata <= ulpi.data_in;
        default: ;
      endcase
      if (state == RX_CMD || (state == RX_DATA && fifo_empty)) ls_rep <= ls_q;
    end
  end

endmodule

// File: tb/tb_ulpi_phy_ctrl.sv
// tb/tb_ulpi_phy_ctrl.sv - vector-table bench for ulpi_phy_ctrl
module tb_ulpi_phy_ctrl;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       stp;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_last;
  logic [1:0] linestate;
  logic [7:0] reg_rdata;

  logic       tx_valid, tx_last, reg_we, rx_ready;
  logic [7:0] tx_data, reg_wdata;
  logic [5:0] reg_addr;
  logic       g_tx_valid, g_tx_last, g_reg_we, g_rx_ready;
  logic [7:0] g_tx_data, g_reg_wdata;
  logic [5:0] g_reg_addr;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  ulpi_phy_ctrl_if u_if ();
  ulpi_phy_ctrl_if g_if ();
  assign u_if.data_in = data_in;
  assign u_if.stp     = stp;
  assign g_if.data_in = data_in;
  assign g_if.stp     = stp;

  ulpi_phy_ctrl #(.RX_DEPTH(4), .TX_NXT_GAP(0)) dut (
    .clock(clock), .reset(reset), .ulpi(u_if.slave),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_last(rx_last), .rx_ready(rx_ready),
    .linestate(linestate), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_rdata(reg_rdata)
  );

  ulpi_phy_ctrl #(.RX_DEPTH(4), .TX_NXT_GAP(2)) dut_gap (
    .clock(clock), .reset(reset), .ulpi(g_if.slave),
    .tx_valid(g_tx_valid), .tx_data(g_tx_data), .tx_last(g_tx_last),
    .rx_valid(1'b0), .rx_data(8'h00), .rx_last(1'b0), .rx_ready(g_rx_ready),
    .linestate(2'b00), .reg_addr(g_reg_addr), .reg_wdata(g_reg_wdata),
    .reg_we(g_reg_we), .reg_rdata(8'h00)
  );

  typedef struct packed {
    logic       rst;
    logic [7:0] din;
    logic       stp;
    logic       rxv;
    logic [7:0] rxd;
    logic       rxl;
    logic [1:0] ls;
  } in_t;

  typedef struct packed {
    logic       dir;
    logic       nxt;
    logic [7:0] dout;
    logic       txv;
    logic [7:0] txd;
    logic       txl;
    logic       we;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic       rdy;
  } out_t;

  typedef struct {
    in_t  in;
    out_t exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic rst, logic [7:0] din, logic stp_i, logic rxv, logic [7:0] rxd,
                             logic rxl, logic [1:0] ls, logic dir, logic nxt, logic [7:0] dout,
                             logic txv, logic [7:0] txd, logic txl, logic we, logic [5:0] addr,
                             logic [7:0] wdata, logic rdy);
    vec_t r;
    r.in  = '{rst, din, stp_i, rxv, rxd, rxl, ls};
    r.exp = '{dir, nxt, dout, txv, txd, txl, we, addr, wdata, rdy};
    return r;
  endfunction

  function automatic out_t get_out();
    return '{u_if.dir, u_if.nxt, u_if.data_out, tx_valid, tx_data, tx_last,
             reg_we, reg_addr, reg_wdata, rx_ready};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic quiet();
    data_in = 8'h00; stp = L; rx_valid = L; rx_data = 8'h00; rx_last = L;
  endtask

  task automatic do_reset();
    @(negedge clock);
    quiet();
    reset = L;
    repeat (2) @(negedge clock);
    reset = H;
    repeat (10) @(negedge clock);
  endtask

  logic [7:0] g_din [9];
  logic       g_stp [9];
  logic [10:0] g_exp [9];

  initial begin
    int idx;
    reset = L; linestate = 2'd0; reg_rdata = 8'h3C;
    quiet();

    vecs.push_back(v(L,8'h00,L,L,8'h00,L,2'd0, L,L,8'h00,L,8'h00,L,L,6'h00,8'h00,L));
    vecs.push_back(v(H,8'h00,L,L,8'h00,L,2'd0, L,L,8'h00,L,8'h00,L,L,6'h00,8'h00,H));
    vecs.push_back(v(H,8'h43,L,L,8'h00,L,2'd0, L,L,8'h00,L,8'h00,L,L,6'h00,8'h00,H));
    vecs.push_back(v(H,8'hAA,L,L,8'h00,L,2'd0, L,H,8'h00,H,8'h43,L,L,6'h00,8'h00,H));
    vecs.push_back(v(H,8'hBB,L,L,8'h00,L,2'd0, L,H,8'h00,H,8'hAA,L,L,6'h00,8'h00,H));
    vecs.push_back(v(H,8'h00,H,L,8'h00,L,2'd0, L,H,8'h00,H,8'hBB,H,L,6'h00,8'h00,H));
    vecs.push_back(v(H,8'h00,L,L,8'h00,L,2'd0, L,L,8'h00,L,8'h00,L,L,6'h00,8'h00,H));
    vecs.push_back(v(H,8'h85,L,L,8'h00,L,2'd0, L,L,8'h00,L,8'h00,L,L,6'h00,8'h00,H));
    vecs.push_back(v(H,8'h5A,L,L,8'h00,L,2'd0, L,H,8'h00,L,8'h00,L,L,6'h05,8'h00,H));
    vecs.push_back(v(H,8'h00,H,L,8'h00,L,2'd0, L,L,8'h00,L,8'h00,L,L,6'h05,8'h5A,H));
    vecs.push_back(v(H,8'h00,L,L,8'h00,L,2'd0, L,L,8'h00,L,8'h00,L,H,6'h05,8'h5A,H));
    vecs.push_back(v(H,8'h00,L,L,8'h00,L,2'd0, L,L,8'h00,L,8'h00,L,L,6'h05,8'h5A,H));
    vecs.push_back(v(H,8'hC7,L,L,8'h00,L,2'd0, L,L,8'h00,L,8'h00,L,L,6'h05,8'h5A,H));
    vecs.push_back(v(H,8'h00,L,L,8'h00,L,2'd0, L,H,8'h00,L,8'h00,L,L,6'h07,8'h5A,H));
    vecs.push_back(v(H,8'h00,L,L,8'h00,L,2'd0, H,L,8'h00,L,8'h00,L,L,6'h07,8'h5A,H));
    vecs.push_back(v(H,8'h00,L,L,8'h00,L,2'd0, H,L,8'h3C,L,8'h00,L,L,6'h07,8'h5A,H));
    vecs.push_back(v(H,8'h00,L,L,8'h00,L,2'd0, L,L,8'h00,L,8'h00,L,L,6'h07,8'h5A,H));
    vecs.push_back(v(H,8'h00,L,H,8'h11,L,2'd1, L,L,8'h00,L,8'h00,L,L,6'h07,8'h5A,H));
    vecs.push_back(v(H,8'h00,L,H,8'h22,L,2'd1, L,L,8'h00,L,8'h00,L,L,6'h07,8'h5A,H));
    vecs.push_back(v(H,8'h00,L,H,8'h33,H,2'd1, H,H,8'h00,L,8'h00,L,L,6'h07,8'h5A,H));
    vecs.push_back(v(H,8'h00,L,L,8'h00,L,2'd1, H,L,8'h11,L,8'h00,L,L,6'h07,8'h5A,H));
    vecs.push_back(v(H,8'h00,L,L,8'h00,L,2'd1, H,H,8'h11,L,8'h00,L,L,6'h07,8'h5A,H));
    vecs.push_back(v(H,8'h00,L,L,8'h00,L,2'd1, H,H,8'h22,L,8'h00,L,L,6'h07,8'h5A,H));
    vecs.push_back(v(H,8'h00,L,L,8'h00,L,2'd1, H,H,8'h33,L,8'h00,L,L,6'h07,8'h5A,H));
    vecs.push_back(v(H,8'h00,L,L,8'h00,L,2'd1, H,L,8'h01,L,8'h00,L,L,6'h07,8'h5A,H));
    vecs.push_back(v(H,8'h00,L,L,8'h00,L,2'd1, L,L,8'h00,L,8'h00,L,L,6'h07,8'h5A,H));
    vecs.push_back(v(H,8'h00,L,L,8'h00,L,2'd1, L,L,8'h00,L,8'h00,L,L,6'h07,8'h5A,H));
    vecs.push_back(v(H,8'h00,L,L,8'h00,L,2'd2, L,L,8'h00,L,8'h00,L,L,6'h07,8'h5A,H));
    vecs.push_back(v(H,8'h00,L,L,8'h00,L,2'd2, L,L,8'h00,L,8'h00,L,L,6'h07,8'h5A,H));
    vecs.push_back(v(H,8'h00,L,L,8'h00,L,2'd2, H,L,8'h00,L,8'h00,L,L,6'h07,8'h5A,H));
    vecs.push_back(v(H,8'h00,L,L,8'h00,L,2'd2, H,L,8'h02,L,8'h00,L,L,6'h07,8'h5A,H));
    vecs.push_back(v(H,8'h00,L,L,8'h00,L,2'd2, L,L,8'h00,L,8'h00,L,L,6'h07,8'h5A,H));
    vecs.push_back(v(H,8'h00,H,L,8'h00,L,2'd2, L,L,8'h00,L,8'h00,L,L,6'h07,8'h5A,H));
    vecs.push_back(v(H,8'h00,L,L,8'h00,L,2'd2, L,L,8'h00,L,8'h00,L,L,6'h07,8'h5A,H));

    repeat (2) @(posedge clock);
    foreach (vecs[i]) begin
      @(negedge clock);
      reset = vecs[i].in.rst; data_in = vecs[i].in.din; stp = vecs[i].in.stp;
      rx_valid = vecs[i].in.rxv; rx_data = vecs[i].in.rxd; rx_last = vecs[i].in.rxl;
      linestate = vecs[i].in.ls;
      #2;
      check($sformatf("vec%0d", i), 64'(get_out()), 64'(vecs[i].exp));
    end

    // FIFO fill to full with rx_valid held, six bytes, last on the sixth
    linestate = 2'd1;
    do_reset();
    idx = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clock);
      rx_valid = (idx < 6);
      rx_data  = 8'hA0 + 8'(idx);
      rx_last  = (idx == 5);
      #2;
      if (c == 4) begin
        check("full_rx_ready", 64'(rx_ready), 64'(L));
        check("full_pop_first", 64'({u_if.dir, u_if.nxt, u_if.data_out}), 64'({H, H, 8'hA0}));
      end
      if (c == 5) check("full_rx_ready_back", 64'(rx_ready), 64'(H));
      if (c == 9) check("full_pop_last", 64'({u_if.dir, u_if.nxt, u_if.data_out}), 64'({H, H, 8'hA5}));
      if (c == 10) check("full_end_rxcmd", 64'({u_if.dir, u_if.nxt, u_if.data_out}), 64'({H, L, 8'h01}));
      if (c == 11) check("full_turn_back", 64'({u_if.dir, u_if.data_out}), 64'({L, 8'h00}));
      if (rx_valid && rx_ready) idx++;
    end
    check("full_all_pushed", 64'(idx), 64'(6));

    // Mid-packet starvation: underrun RXCMD with nxt=0 until the next byte lands
    for (int d = 0; d < 12; d++) begin
      @(negedge clock);
      rx_valid = (d == 0) || (d == 6);
      rx_data  = (d == 0) ? 8'h55 : 8'h66;
      rx_last  = (d == 6);
      #2;
      if (d == 4) check("starve_first", 64'({u_if.dir, u_if.nxt, u_if.data_out}), 64'({H, H, 8'h55}));
      if (d == 5) check("starve_stall_a", 64'({u_if.dir, u_if.nxt, u_if.data_out}), 64'({H, L, 8'h11}));
      if (d == 6) check("starve_stall_b", 64'({u_if.dir, u_if.nxt, u_if.data_out}), 64'({H, L, 8'h11}));
      if (d == 7) check("starve_resume", 64'({u_if.dir, u_if.nxt, u_if.data_out}), 64'({H, H, 8'h66}));
      if (d == 8) check("starve_end", 64'({u_if.dir, u_if.nxt, u_if.data_out}), 64'({H, L, 8'h01}));
      if (d == 9) check("starve_turn_back", 64'(u_if.dir), 64'(L));
    end

    // RX wins over a TXCMD in the same IDLE cycle, then reset during RX_DATA
    quiet();
    for (int f = 0; f < 8; f++) begin
      @(negedge clock);
      rx_valid = (f < 3);
      rx_data  = 8'h77 + 8'(f);
      data_in  = (f == 1) ? 8'h43 : 8'h00;
      reset    = (f == 5) ? L : H;
      #2;
      if (f == 2) check("drop_txcmd", 64'({u_if.dir, u_if.nxt, tx_valid}), 64'({H, H, L}));
      if (f == 3) check("drop_rxcmd", 64'({u_if.dir, u_if.nxt, u_if.data_out}), 64'({H, L, 8'h11}));
      if (f == 4) check("drop_pop", 64'({u_if.dir, u_if.nxt, u_if.data_out}), 64'({H, H, 8'h77}));
      if (f == 6) check("rst_rx_dir", 64'({u_if.dir, u_if.nxt, tx_valid, rx_ready}), 64'({L, L, L, H}));
      if (f == 7) check("rst_rx_flushed", 64'(u_if.dir), 64'(L));
    end

    // TX nxt throttle on the TX_NXT_GAP=2 instance
    g_din = '{8'h41, 8'hB1, 8'hB2, 8'hEE, 8'hB3, 8'hB4, 8'hEE, 8'h00, 8'h00};
    g_stp = '{L, L, L, L, L, L, L, H, L};
    g_exp = '{{L, L, 8'h00, L}, {H, H, 8'h41, L}, {H, H, 8'hB1, L}, {L, L, 8'h00, L},
              {H, H, 8'hB2, L}, {H, H, 8'hB3, L}, {L, L, 8'h00, L}, {H, H, 8'hB4, H},
              {L, L, 8'h00, L}};
    do_reset();
    for (int e = 0; e < 9; e++) begin
      @(negedge clock);
      data_in = g_din[e];
      stp     = g_stp[e];
      #2;
      check($sformatf("gap%0d", e), 64'({g_if.nxt, g_tx_valid, g_tx_data, g_tx_last}), 64'(g_exp[e]));
    end
    quiet();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule
